// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), SLICE bits per clock behind valid/ready.
// Optional: define SLU_ZERO_FLAG_EN to register a result==0 flag on entry to DONE.
module serial_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             zero
);

    localparam int NSLICES = WIDTH / SLICE;
    localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [1:0]        op_reg;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic              accept;
    logic              last_slice;

    function automatic logic [SLICE-1:0] logic_op(input logic [1:0] o,
                                                  input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y);
        case (o)
            2'b00:   logic_op = x & y;
            2'b01:   logic_op = x | y;
            2'b10:   logic_op = x ^ y;
            default: logic_op = ~(x | y);
        endcase
    endfunction

    assign accept     = (state_reg == IDLE) && in_valid;
    assign last_slice = (cnt_reg == CW'(NSLICES - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = BUSY;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                if (last_slice) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Each slice lane is written only on its own counter value; accept clears the whole word.
    generate
        for (genvar gi = 0; gi < NSLICES; gi++) begin : g_slice
            logic [SLICE-1:0] slice_val;
            logic             slice_wr;
            assign slice_val = logic_op(op_reg, a_reg[gi*SLICE +: SLICE], b_reg[gi*SLICE +: SLICE]);
            assign slice_wr  = (state_reg == BUSY) && (cnt_reg == CW'(gi));
            assign result_next[gi*SLICE +: SLICE] = accept   ? {SLICE{1'b0}} :
                                                    slice_wr ? slice_val :
                                                               result_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            if (accept) begin
                a_reg  <= first;
                b_reg  <= second;
                op_reg <= op;
            end
        end
    end

`ifdef SLU_ZERO_FLAG_EN
    logic zero_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_reg <= 1'b0;
        end else if (accept) begin
            zero_reg <= 1'b0;
        end else if ((state_reg == BUSY) && last_slice) begin
            zero_reg <= (result_next == '0);
        end
    end

    assign zero = zero_reg;
`else
    assign zero = 1'b0;
`endif

    assign result    = result_reg;
    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == BUSY);
    assign out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_serial_logic_unit.sv
// Scoreboard bench for serial_logic_unit: 32/8 instance with random and directed ops, plus a 16/16 single-cycle instance.
module tb_serial_logic_unit;

    localparam int NS = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy, zero;
    logic [1:0]  op;
    logic [31:0] first, second, result;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16, zero16;
    logic [1:0]  op16;
    logic [15:0] first16, second16, result16;

    serial_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .first(first), .second(second), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .zero(zero)
    );

    serial_logic_unit #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .first(first16), .second(second16), .result(result16),
        .out_valid(out_valid16), .out_ready(out_ready16), .busy(busy16), .zero(zero16)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rand_ready = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic zexp(input logic [31:0] r);
`ifdef SLU_ZERO_FLAG_EN
        return (r == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got result %h expected no output", result);
            end else begin
                check("result", result, sb[0].res);
                check("zero", {31'd0, zero}, {31'd0, sb[0].z});
                if (!prev_ov) check("latency", 32'(cyc - sb[0].acc), 32'(NS));
                if (out_ready) begin
                    $display("txn done result=%h zero=%b", result, zero);
                    void'(sb.pop_front());
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, output int acc);
        int n = 0;
        acc = -1;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed %b required 1", in_ready);
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b1;
        op       = o;
        first    = a;
        second   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc      = cyc;
        sb.push_back('{exp, zexp(exp), cyc});
        first  = $urandom;
        second = $urandom;
        op     = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0) begin
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d results pending required 0", sb.size());
                sb.delete();
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int acc1, acc2, n;
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [15:0] a16, b16, e16;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; first = '0; second = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; op16 = 2'b00; first16 = '0; second16 = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        reset_n = 1'b1;

        // NOR with busy window of exactly NS cycles
        do_op(2'b11, 32'hF114002A, 32'h0F0F0F0F, 32'h00E0F0D0, acc1);
        for (int i = 0; i < NS; i++) begin
            check("busy_window", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        check("busy_end", {31'd0, busy}, 32'd0);
        wait_drain();

        // Back-to-back throughput with out_ready high
        do_op(2'b11, 32'hBAAACC00, 32'hDBB44050, 32'h044133AF, acc1);
        do_op(2'b00, 32'hBAAACC00, 32'hDBB44050, 32'h9AA04000, acc2);
        check("throughput", 32'(acc2 - acc1), 32'(NS + 2));
        do_op(2'b10, 32'h12345678, 32'h12345678, 32'h00000000, acc1);
        wait_drain();

        // Backpressure: held DONE, in_valid pulses ignored
        out_ready = 1'b0;
        a = $urandom; b = $urandom;
        do_op(2'b11, a, b, ref_op(2'b11, a, b), acc1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            in_valid = 1'(i % 2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        repeat (NS + 3) @(negedge clk);
        check("bp_idle", {31'd0, in_ready}, 32'd1);

        // Reset mid-BUSY after two slices
        a = $urandom; b = $urandom;
        do_op(2'b01, a, b, ref_op(2'b01, a, b), acc1);
        void'(sb.pop_back());
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(2'b01, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, acc1);
        wait_drain();

        // Random ops with random consumer backpressure
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 8 == 3) ? a : $urandom;
            do_op(o, a, b, ref_op(o, a, b), acc1);
        end
        wait_drain();
        rand_ready = 0;
        #2 out_ready = 1'b1;

        // Single-cycle configuration: WIDTH=16, SLICE=16
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                o = 2'b01; a16 = 16'h00F0; b16 = 16'h0F00; e16 = 16'h0FF0;
            end else begin
                o = 2'($urandom_range(0, 3)); a16 = 16'($urandom); b16 = 16'($urandom);
                e16 = 16'(ref_op(o, {16'd0, a16}, {16'd0, b16}));
            end
            check("w16_in_ready", {31'd0, in_ready16}, 32'd1);
            in_valid16 = 1'b1; op16 = o; first16 = a16; second16 = b16;
            @(posedge clk);
            #1;
            in_valid16 = 1'b0; first16 = 16'($urandom); second16 = 16'($urandom);
            check("w16_busy", {31'd0, busy16}, 32'd1);
            check("w16_early_valid", {31'd0, out_valid16}, 32'd0);
            @(posedge clk);
            #1;
            check("w16_out_valid", {31'd0, out_valid16}, 32'd1);
            check("w16_result", {16'd0, result16}, {16'd0, e16});
            $display("txn16 done op=%0d result=%h", o, result16);
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_logic_unit.md
# serial_logic_unit

Parametrised, multi-cycle bitwise logic unit for the MiniMIPS datapath. It generalises the combinational 32-bit NOR to AND/OR/XOR/NOR on WIDTH-bit operands. Operands are processed SLICE bits per clock behind a valid/ready handshake, so wide operations can share narrow logic. It sits beside the ALU and is driven by the multi-cycle control unit.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of SLICE.
- SLICE, 8: bits processed per clock; NSLICES = WIDTH/SLICE; SLICE == WIDTH is legal (single-cycle).
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept an operation.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- first  input  WIDTH  operand A.
- second  input  WIDTH  operand B.
- result  output  WIDTH  registered result.
- out_valid  output  1  result is complete and stable.
- out_ready  input  1  consumer takes result.
- busy  output  1  high in BUSY.
- zero  output  1  result == 0 (see Configuration).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0. When in_valid && in_ready at an edge: latch first, second, op; clear result; slice counter cnt=0; go to BUSY.
- BUSY: each edge writes result[cnt*SLICE +: SLICE] = op(A_slice, B_slice) from latched operands; cnt++. After the slice with cnt == NSLICES-1 is written, go to DONE.
- DONE: out_valid=1; result and zero held stable. When out_ready=1 at an edge, go to IDLE.
- in_ready=0 in BUSY and DONE; in_valid in those states is ignored and does not queue.
- Input ports may change freely after acceptance; only latched copies are used.
- out_ready outside DONE is ignored.
- Counter width is clog2(NSLICES), minimum 1; cnt never exceeds NSLICES-1.
- Reset (any state, including mid-BUSY): aborts immediately. Outputs: state IDLE, in_ready=1, out_valid=0, busy=0, result=0, zero=0, cnt=0, latched operands=0.

## Timing
- Accept at edge k -> busy high in cycles k..k+NSLICES-1 -> out_valid high from edge k+NSLICES.
- Latency: NSLICES clocks from accept to out_valid. With SLICE == WIDTH, the latency is 1.
- A partial result is visible on result during BUSY. It is valid only when out_valid=1.
- Back-to-back throughput: one operation per NSLICES+2 clocks when out_ready is held high (1 DONE cycle, 1 IDLE cycle).
- out_valid stays high indefinitely until out_ready is sampled high.
- There is no combinational path from any input to any output. All outputs are registered or decoded from state.

## Configuration
- SLU_ZERO_FLAG_EN defined: zero is registered on the transition into DONE as (final result == 0). It is held through DONE and cleared on accept of the next operation and on reset.
- SLU_ZERO_FLAG_EN undefined: zero is tied to 0 and no compare logic is synthesised.

## Test plan
- WIDTH=32, SLICE=8, op=NOR, first=F114002A, second=0F0F0F0F -> busy for 4 cycles; out_valid at accept+4; result=00E0F0D0; zero=0.
- op=NOR, first=BAAACC00, second=DBB44050, out_ready held 1 -> result=044133AF. Next accept is possible 2 clocks after out_valid rises. Changing first/second during BUSY does not alter result.
- op=AND on BAAACC00/DBB44050 -> 9AA04000. op=XOR on equal operands 12345678/12345678 -> result=00000000, zero=1 (with SLU_ZERO_FLAG_EN), zero=0 without.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid, result and zero are stable. in_valid pulses meanwhile are ignored and in_ready=0. Releasing out_ready returns to IDLE.
- reset_n low for 1 cycle mid-BUSY (after 2 slices) -> asynchronously in_ready=1, busy=0, out_valid=0, result=0. A fresh OR of 0000FFFF/FFFF0000 then yields FFFFFFFF.
- WIDTH=16, SLICE=16, op=OR, first=00F0, second=0F00 -> out_valid one cycle after accept; result=0FF0.
